rca_pipe_nbit: RTL and testbench
================================

Name: rca_pipe_nbit

Overview:
- Pipelined, parametrised ripple-carry add/subtract unit, the clocked successor to the combinational n-bit ripple adder.
- Splits a WIDTH-bit operation into STAGES chunks; each chunk ripples through its own FA chain in one pipeline stage.
- Uses a valid/ready handshake with full backpressure and bubble collapsing.
- Sits between a producer of operand pairs and a consumer of results, e.g. in accumulator and datapath blocks that need wide adds at high clock rates.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages and carry chunks; 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair presented
- in_ready  output  1  unit accepts operands this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- cin  input  1  carry-in (ignored when sub=1)
- sub  input  1  0: x+y+cin; 1: x-y (x + ~y + 1)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result this cycle
- sum  output  WIDTH  result
- cout  output  1  carry-out; in sub mode, 1 = no borrow (x >= y unsigned)
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Constants and width rules:
  - CHUNK = WIDTH/STAGES.
  - Stage k (1..STAGES) adds bits [k*CHUNK-1:(k-1)*CHUNK] using the carry registered by stage k-1.
  - Stage 1 uses cin, or 1 when sub=1.
  - Operand y is inverted at entry when sub=1.
- Stage registers:
  - Each stage holds valid, the sum bits completed so far, the operand bits not yet consumed, the running carry, and the carry into the MSB.
  - The last stage also holds the carry into the MSB, used to form ovf.
- Handshake:
  - adv[STAGES] = !v[STAGES] | out_ready.
  - adv[k] = !v[k] | adv[k+1].
  - in_ready = adv[1], combinational; no registered skid.
  - A transfer occurs on a rising edge where valid & ready are both high.
  - A stage loads from its predecessor when adv[k]=1. If the predecessor is invalid, the stage's valid clears.
  - Bubbles collapse: an empty stage accepts data even while downstream stages stall.
- Latency:
  - Exactly STAGES cycles from input transfer to out_valid with no stall.
  - Throughput is one result per cycle.
- Outputs:
  - out_valid, sum, cout and ovf are driven directly from the last-stage registers; no combinational path from x/y to outputs.
  - They hold stable while out_valid=1 and out_ready=0.
- Reset:
  - rst_n low asserts immediately and asynchronously. All valid bits, data and carry registers, sum, cout, ovf and out_valid go to 0.
  - in_ready reads 1 during and after reset, since all stages are empty.
  - Reset mid-operation discards every in-flight operation with no partial result.
  - Deassertion is synchronised externally; the block requires only that rst_n be released away from the clock edge.
- Boundaries:
  - Unsigned wrap: 0xFFFF + 1 gives sum=0x0000, cout=1.
  - Signed overflow: 0x7FFF + 1 gives ovf=1. In sub mode, 0x8000 - 1 gives ovf=1.
  - Backpressure with a full pipe: in_ready=0, no data loss, and order is preserved.
  - Simultaneous out_ready and in_valid on a full pipe: output transfer and input acceptance both occur in the same cycle.
  - STAGES=1 degenerates to a single registered ripple adder with one-cycle latency.

Decomposition:
- Shared package rca_pkg:
  - function for CHUNK computation
  - elaboration-time check that WIDTH % STAGES == 0
  - localparam for the default widths
- Sub-module rca_chunk: parametrised CHUNK-bit combinational ripple chain built from the existing FA cell, with ports x, y, cin, sum, cout, and c_msb (carry into its top bit).
- The top level instantiates one rca_chunk per stage in a generate loop and owns all registers and handshake logic.

Test Plan:
- Reset and single op: with WIDTH=16 and STAGES=4, rst_n low mid-stream then high; send x=0x1234, y=0x1111, cin=0, sub=0. Expect sum=0x2345, cout=0 and ovf=0 exactly 4 cycles later, with out_valid high for one cycle when out_ready=1.
- Carry across all chunks: x=0xFFFF, y=0x0001, cin=0. Expect sum=0x0000, cout=1, ovf=0. Then x=0x7FFF, y=0x0001: expect sum=0x8000, cout=0, ovf=1.
- Subtract mode: x=0x0005, y=0x0007, sub=1, giving sum=0xFFFE, cout=0. Then x=0x8000, y=0x0001: sum=0x7FFF, cout=1, ovf=1. Also confirm cin is ignored when sub=1.
- Backpressure: stream 10 back-to-back ops, hold out_ready=0 for 6 cycles from cycle 5. Expect in_ready to drop once 4 ops are held, out_data stable while stalled, all 10 results in order, and no drops or duplicates.
- Bubble collapse: send ops with gaps (valid pattern 1,0,1,0,1) while out_ready=0. Expect the three ops to pack into stages 4, 3 and 2, and in_ready to stay 1.
- Randomised check: 5000 random x/y/cin/sub with random in_valid and out_ready, compared against a reference model of x±y. Also run with STAGES=1 and STAGES=16.

Source files
------------

// File: rtl/rca_pkg.sv
// rca_pkg: shared constants and helpers for the pipelined ripple-carry
// add/subtract unit.
//   RCA_WIDTH_DEF / RCA_STAGES_DEF : default operand width and stage count
//   rca_chunk_width()              : bits handled by each pipeline stage
//   rca_cfg_ok()                   : legality of a WIDTH/STAGES pairing
package rca_pkg;

  localparam int unsigned RCA_WIDTH_DEF  = 16;
  localparam int unsigned RCA_STAGES_DEF = 4;

  function automatic int unsigned rca_chunk_width(input int unsigned width,
                                                  input int unsigned stages);
    // Guard against a zero stage count so the legality check can report it
    // instead of elaboration dying on a divide by zero.
    return (stages == 0) ? width : width / stages;
  endfunction

  function automatic bit rca_cfg_ok(input int unsigned width,
                                    input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/rca_pipe_nbit_if.sv
// rca_pipe_nbit_if: operand/result handshake bundle for rca_pipe_nbit.
//   Input side : in_valid, in_ready, x, y, cin, sub
//   Output side: out_valid, out_ready, sum, cout, ovf
//   master = producer/consumer side, slave = adder side.
interface rca_pipe_nbit_if
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = RCA_WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/rca_chunk.sv
// rca_chunk: CW-bit combinational ripple-carry chain of full-adder cells.
//   x, y  : chunk operands
//   cin   : carry into bit 0
//   sum   : chunk sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (used for signed overflow)
module rca_chunk
  import rca_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          c_msb
);

  logic [CW:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < CW; gi++) begin : g_fa
    assign sum[gi]  = x[gi] ^ y[gi] ^ c[gi];
    assign c[gi+1]  = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
  end

  assign cout  = c[CW];
  assign c_msb = c[CW-1];

endmodule

// File: rtl/rca_pipe_nbit.sv
// rca_pipe_nbit: pipelined WIDTH-bit ripple-carry add/subtract unit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of rca_pipe_nbit_if (operands in, result out)
// Stage k adds chunk k-1 using the carry registered by the stage before it.
// Each stage register holds the low sum bits finished so far merged with
// the high x bits still to be consumed, the remaining y bits (shifted down
// so the next chunk is always at the bottom), the running carry and the
// carry into the chunk's top bit. Results leave from the last stage only.
module rca_pipe_nbit
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH  = RCA_WIDTH_DEF,
  parameter int unsigned STAGES = RCA_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  rca_pipe_nbit_if.slave   bus
);

  localparam int unsigned CHUNK = rca_chunk_width(WIDTH, STAGES);

  if (!rca_cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("rca_pipe_nbit: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // Stage registers, index 0 is the first stage.
  logic             v_q  [STAGES];
  logic [WIDTH-1:0] s_q  [STAGES];
  logic [WIDTH-1:0] y_q  [STAGES];
  logic             c_q  [STAGES];
  logic             cm_q [STAGES];

  // What each stage sees from its predecessor (or from the input port).
  logic             v_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic [WIDTH-1:0] y_in [STAGES];
  logic             c_in [STAGES];

  // adv[k]: stage k may load this cycle. adv[STAGES] is the consumer.
  logic [STAGES:0] adv;

  assign adv[STAGES] = bus.out_ready;
  assign bus.in_ready = adv[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int unsigned LO = gi * CHUNK;

    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout;
    logic             ch_cmsb;
    logic [WIDTH-1:0] s_d;

    if (gi == 0) begin : g_src
      // Subtraction is x + ~y + 1: invert y once on entry, force carry-in.
      assign v_in[gi] = bus.in_valid;
      assign s_in[gi] = bus.x;
      assign y_in[gi] = bus.sub ? ~bus.y : bus.y;
      assign c_in[gi] = bus.sub | bus.cin;
    end else begin : g_src
      assign v_in[gi] = v_q[gi-1];
      assign s_in[gi] = s_q[gi-1];
      assign y_in[gi] = y_q[gi-1];
      assign c_in[gi] = c_q[gi-1];
    end

    // An empty stage can always load, so bubbles collapse under a stall.
    assign adv[gi] = !v_q[gi] | adv[gi+1];

    rca_chunk #(
      .CW (CHUNK)
    ) u_chunk (
      .x     (s_in[gi][LO +: CHUNK]),
      .y     (y_in[gi][CHUNK-1:0]),
      .cin   (c_in[gi]),
      .sum   (ch_sum),
      .cout  (ch_cout),
      .c_msb (ch_cmsb)
    );

    // Replace the consumed x chunk in place with its sum bits.
    always_comb begin
      s_d = s_in[gi];
      s_d[LO +: CHUNK] = ch_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[gi]  <= 1'b0;
        s_q[gi]  <= '0;
        y_q[gi]  <= '0;
        c_q[gi]  <= 1'b0;
        cm_q[gi] <= 1'b0;
      end else if (adv[gi]) begin
        v_q[gi] <= v_in[gi];
        // Data only moves with a valid token, so a drained stage keeps its
        // last contents rather than toggling on bubbles.
        if (v_in[gi]) begin
          s_q[gi]  <= s_d;
          y_q[gi]  <= y_in[gi] >> CHUNK;
          c_q[gi]  <= ch_cout;
          cm_q[gi] <= ch_cmsb;
        end
      end
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = c_q[STAGES-1] ^ cm_q[STAGES-1];

endmodule

// File: tb/tb_rca_pipe_nbit.sv
// tb_rca_pipe_nbit: directed and streamed checks of rca_pipe_nbit with
// WIDTH=16, STAGES=4. Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge.
module tb_rca_pipe_nbit;
  import rca_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rca_pipe_nbit_if #(.WIDTH(W)) bus ();

  rca_pipe_nbit #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [17:0] exp_q[$];
  logic [17:0] mon_e;
  logic [17:0] held;
  bit mon_en = 0;
  bit quiet = 0;
  bit stall_prev = 0;
  bit blocked_prev = 0;
  bit saw_backpressure = 0;
  bit saw_full_swap = 0;
  bit prod_done = 0;
  int n_in = 0;
  int n_out = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} of x + y + cin, or x - y.
  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb);
    logic [15:0] bb;
    logic [16:0] full;
    logic ov;
    bb   = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, (sb | ci)};
    ov   = (a[15] == bb[15]) && (full[15] != a[15]);
    return {ov, full[16], full[15:0]};
  endfunction

  // Scoreboard / protocol monitor for streamed phases.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (stall_prev) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'({bus.ovf, bus.cout, bus.sum}), 32'(held));
      end
      if (bus.in_valid && !bus.in_ready) saw_backpressure = 1;
      if (blocked_prev && bus.in_valid && bus.in_ready && bus.out_valid && bus.out_ready)
        saw_full_swap = 1;
      if (bus.out_valid && bus.out_ready) begin
        check("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("stream_result", 32'({bus.ovf, bus.cout, bus.sum}), 32'(mon_e));
        end
        if (!quiet)
          $display("out %0d: sum=%h cout=%b ovf=%b", n_out, bus.sum, bus.cout, bus.ovf);
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_add(bus.x, bus.y, bus.cin, bus.sub));
        n_in++;
      end
      stall_prev   = bus.out_valid && !bus.out_ready;
      held         = {bus.ovf, bus.cout, bus.sum};
      blocked_prev = bus.in_valid && !bus.in_ready;
    end else begin
      stall_prev   = 0;
      blocked_prev = 0;
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic push_op(input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sb);
    bit taken;
    taken = 0;
    bus.x = a;
    bus.y = b;
    bus.cin = ci;
    bus.sub = sb;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 300 && !taken; t++) begin
      @(negedge clk);
      taken = bus.in_ready;
      @(posedge clk);
      #1;
    end
    check("accept_in_time", 32'(taken), 32'd1);
  endtask

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 300; t++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // One isolated op: checks exact STAGES-cycle latency and one-cycle output.
  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sb, input logic [17:0] exp);
    bus.x = a;
    bus.y = b;
    bus.cin = ci;
    bus.sub = sb;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int i = 1; i < int'(S); i++) begin
      @(negedge clk);
      check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_result"}, 32'({bus.ovf, bus.cout, bus.sum}), 32'(exp));
    $display("vec %s: x=%h y=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b",
             tag, a, b, ci, sb, bus.sum, bus.cout, bus.ovf);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_one_cycle"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ghost;
    bit pat[5];

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state, before any clock edge.
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_outputs", 32'({bus.ovf, bus.cout, bus.sum}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a stalled stream discards everything.
    push_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    push_op(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    push_op(16'h4000, 16'h0001, 1'b0, 1'b1);
    idle_cycle();
    idle_cycle();
    idle_cycle();
    @(negedge clk);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_ready", 32'(bus.in_ready), 32'd1);
    check("async_rst_data", 32'({bus.ovf, bus.cout, bus.sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    ghost = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) ghost++;
      @(posedge clk);
      #1;
    end
    check("no_partial_after_rst", 32'(ghost), 32'd0);

    // Directed vectors, hand-computed {ovf, cout, sum}.
    run_vec("add_basic",   16'h1234, 16'h1111, 1'b0, 1'b0, 18'h02345);
    run_vec("add_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
    run_vec("add_sovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
    run_vec("add_cin",     16'h00FF, 16'h0F01, 1'b1, 1'b0, 18'h01001);
    run_vec("add_negovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 18'h30000);
    run_vec("sub_borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE);
    run_vec("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF);
    run_vec("sub_cin_ign", 16'h0005, 16'h0007, 1'b1, 1'b1, 18'h0FFFE);
    run_vec("sub_noborr",  16'h1234, 16'h1111, 1'b0, 1'b1, 18'h10123);

    // Backpressure: 10 back-to-back ops, consumer stalls 6 cycles from cycle 5.
    mon_en = 1;
    n_in = 0;
    n_out = 0;
    saw_backpressure = 0;
    saw_full_swap = 0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          push_op(16'(i * 16'h1357), 16'hF00F ^ 16'(i), i[0], i[1]);
        idle_cycle();
      end
      begin
        bus.out_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        bus.out_ready = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_in_ready_dropped", 32'(saw_backpressure), 32'd1);
    check("bp_full_swap", 32'(saw_full_swap), 32'd1);
    check("bp_out_count", 32'(n_out), 32'd10);
    check("bp_in_count", 32'(n_in), 32'd10);

    // Bubble collapse: valid pattern 1,0,1,0,1 while the consumer stalls.
    n_in = 0;
    n_out = 0;
    bus.out_ready = 1'b0;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = pat[i];
      bus.x = (i == 0) ? 16'h0001 : (i == 2) ? 16'h00F0 : 16'hFFFF;
      bus.y = (i == 0) ? 16'h0002 : (i == 2) ? 16'h000F : 16'h0001;
      bus.cin = 1'b0;
      bus.sub = (i == 4);
      @(negedge clk);
      check("bubble_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    idle_cycle();
    @(negedge clk);
    check("bubble_head_valid", 32'(bus.out_valid), 32'd1);
    check("bubble_head_data", 32'({bus.ovf, bus.cout, bus.sum}), 32'h00003);
    check("bubble_stage1_free", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    push_op(16'h0100, 16'h0200, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bubble_full_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();
    check("bubble_out_count", 32'(n_out), 32'd4);

    // Random traffic against the reference model.
    quiet = 1;
    n_in = 0;
    n_out = 0;
    prod_done = 0;
    fork
      begin
        for (int i = 0; i < 5000; i++) begin
          if ($urandom_range(0, 3) == 0) idle_cycle();
          push_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle_cycle();
        prod_done = 1;
      end
      begin
        while (!prod_done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("rand_out_count", 32'(n_out), 32'd5000);
    mon_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
